// File: rtl/dec_arb4_pkg.sv
// Shared definitions for the 4-way arbiter: FSM encodings and the default hold limit.
// The testbench imports this package so both sides agree on them.
package dec_arb4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int MAX_HOLD_DEF = 8;
    localparam int CNT_W        = 4;

endpackage

// File: rtl/dec_arb4_rr_pick4.sv
// Round-robin selector: first asserted request at or after last+1, wrapping mod 4.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand;

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        idx  = last + 2'd1;
        cand = '0;
        for (int i = 3; i >= 0; i--) begin
            cand = last + 2'd1 + 2'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/dec_arb4.sv
// Four-requester round-robin arbiter driving a 2-to-4 polarity decoder (A2 = polarity, A1:A0 = index).
// Every output is a flop; a one-cycle GAP separates consecutive grants.
module dec_arb4
    import dec_arb4_pkg::*;
#(
    parameter int   MAX_HOLD    = MAX_HOLD_DEF,
    parameter logic POL_DEFAULT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       pol_in,
    input  logic       pol_wr,
    output logic       A2,
    output logic       A1,
    output logic       A0,
    output logic       en,
    output logic [3:0] gnt
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    state_t           state, state_nxt;
    logic [1:0]       last_owner, last_nxt;
    logic [1:0]       owner, owner_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [3:0]       gnt_nxt;
    logic             en_nxt, a2_nxt;
    logic             pend_vld, pend_vld_nxt, pend_pol, pend_pol_nxt;
    logic [1:0]       pick_idx;
    logic             pick_any;
    logic             hold_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v < HOLD_MAX) ? v + 1'b1 : HOLD_MAX;
    endfunction

    rr_pick4 u_pick (
        .req  (req),
        .last (last_owner),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign owner   = {A1, A0};
    assign hold_ok = req[owner] && (hold_cnt < HOLD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 2'd3;
            hold_cnt   <= '0;
            gnt        <= '0;
            en         <= 1'b0;
            A2         <= POL_DEFAULT;
            A1         <= 1'b0;
            A0         <= 1'b0;
            pend_vld   <= 1'b0;
            pend_pol   <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_nxt;
            hold_cnt   <= hold_nxt;
            gnt        <= gnt_nxt;
            en         <= en_nxt;
            A2         <= a2_nxt;
            A1         <= owner_nxt[1];
            A0         <= owner_nxt[0];
            pend_vld   <= pend_vld_nxt;
            pend_pol   <= pend_pol_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = GRANT;
            GRANT:   if (!hold_ok) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt      = gnt;
        en_nxt       = en;
        owner_nxt    = owner;
        last_nxt     = last_owner;
        hold_nxt     = hold_cnt;
        a2_nxt       = A2;
        pend_vld_nxt = pend_vld;
        pend_pol_nxt = pend_pol;
        case (state)
            IDLE: begin
                // Polarity write lands on the same edge as the grant, so the grant sees it.
                if (pol_wr) a2_nxt = pol_in;
                if (pick_any) begin
                    gnt_nxt   = 4'b0001 << pick_idx;
                    en_nxt    = 1'b1;
                    owner_nxt = pick_idx;
                    last_nxt  = pick_idx;
                    hold_nxt  = CNT_W'(1);
                end
            end
            GRANT: begin
                if (pol_wr) begin
                    pend_vld_nxt = 1'b1;
                    pend_pol_nxt = pol_in;
                end
                if (hold_ok) begin
                    hold_nxt = sat_inc(hold_cnt);
                end else begin
                    gnt_nxt      = '0;
                    en_nxt       = 1'b0;
                    hold_nxt     = '0;
                    pend_vld_nxt = 1'b0;
                    if (pol_wr)        a2_nxt = pol_in;
                    else if (pend_vld) a2_nxt = pend_pol;
                end
            end
            GAP: begin
                if (pol_wr) a2_nxt = pol_in;
            end
            default: begin
                gnt_nxt = '0;
                en_nxt  = 1'b0;
            end
        endcase
    end

endmodule
